// File: rtl/spider_pkg.sv
// spider_pkg: shared types and helpers for the spider_mesh lane-permutation
// pipeline.
//   mode_e      : routing mode carried with every beat (3 is reserved and
//                 decodes as STRAIGHT).
//   MASK_MAX_W  : widest swap mask swap_en() accepts.
//   swap_en()   : swap decision for one butterfly stage, given the beat's
//                 mode and mask.
package spider_pkg;

    typedef enum logic [1:0] {
        STRAIGHT = 2'd0,
        REVERSE  = 2'd1,
        MASK     = 2'd2
    } mode_e;

    localparam int MASK_MAX_W = 32;
    localparam int MASK_SEL_W = $clog2(MASK_MAX_W);

    // REVERSE swaps every cell, because lane j XOR (LANES-1) = LANES-1-j.
    // MASK swaps stage s exactly when mask bit s is set, giving lane j XOR mask.
    function automatic logic swap_en(
        input logic [1:0]            mode,
        input logic [MASK_MAX_W-1:0] mask,
        input int                    stage
    );
        logic en;
        en = 1'b0;
        case (mode)
            REVERSE: en = 1'b1;
            MASK:    en = mask[stage[MASK_SEL_W-1:0]];
            default: en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/spider_stage.sv
// spider_stage: one register stage of the spider_mesh pipeline.
// Holds a full bit together with the lane data and the beat's mode and mask.
// When BFLY_S >= 0, the stage applies a butterfly of 2x2 swap cells on the
// way in. Each cell pairs lane i with lane i + 2^BFLY_S. When BFLY_S = -1,
// the data passes through unchanged.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   up_valid_i/up_ready_o  : upstream handshake
//   up_data_i/mode/mask    : incoming beat and its routing
//   dn_valid_o/dn_ready_i  : downstream handshake
//   dn_data_o/mode/mask    : registered beat and its routing
module spider_stage
    import spider_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int WIDTH  = 8,
    parameter int LOG2L  = 2,
    parameter int BFLY_S = -1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   up_valid_i,
    output logic                   up_ready_o,
    input  logic [LANES*WIDTH-1:0] up_data_i,
    input  logic [1:0]             up_mode_i,
    input  logic [LOG2L-1:0]       up_mask_i,
    output logic                   dn_valid_o,
    input  logic                   dn_ready_i,
    output logic [LANES*WIDTH-1:0] dn_data_o,
    output logic [1:0]             dn_mode_o,
    output logic [LOG2L-1:0]       dn_mask_o
);

    localparam int DW = LANES * WIDTH;

    logic             full_q, full_d;
    logic [DW-1:0]    data_q, data_d;
    logic [1:0]       mode_q, mode_d;
    logic [LOG2L-1:0] mask_q, mask_d;
    logic [DW-1:0]    routed;

    genvar gi;
    generate
        if (BFLY_S < 0) begin : g_pass
            assign routed = up_data_i;
        end else begin : g_bfly
            logic swap;
            assign swap = swap_en(up_mode_i, MASK_MAX_W'(up_mask_i), BFLY_S);
            // Each lane takes its partner's data when the stage swaps.
            // Both members of a pair do this, so one cell is a 2x2 swap.
            for (gi = 0; gi < LANES; gi++) begin : g_lane
                localparam int PARTNER = gi ^ (1 << BFLY_S);
                assign routed[gi*WIDTH +: WIDTH] = swap ? up_data_i[PARTNER*WIDTH +: WIDTH]
                                                        : up_data_i[gi*WIDTH +: WIDTH];
            end
        end
    endgenerate

    // The stage loads when it is empty or when its beat leaves this cycle.
    // The ready chain is combinational, so a full pipeline streams with no
    // bubbles.
    assign up_ready_o = !full_q || dn_ready_i;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        mode_d = mode_q;
        mask_d = mask_q;
        if (up_ready_o) begin
            full_d = up_valid_i;
            // The payload is held when no beat arrives. This keeps the data
            // outputs quiet when the input is idle.
            if (up_valid_i) begin
                data_d = routed;
                mode_d = up_mode_i;
                mask_d = up_mask_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            mode_q <= '0;
            mask_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            mode_q <= mode_d;
            mask_q <= mask_d;
        end
    end

    assign dn_valid_o = full_q;
    assign dn_data_o  = data_q;
    assign dn_mode_o  = mode_q;
    assign dn_mask_o  = mask_q;

endmodule

// File: rtl/spider_mesh.sv
// spider_mesh: pipelined lane-permutation mesh.
// The pipeline has STAGES = LOG2L+2 stages:
//   - an input register;
//   - LOG2L butterfly stages, where stage s pairs lanes i and i+2^s;
//   - an output register.
// Each beat carries its own mode and mask through the pipeline.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake (in_ready is combinational)
//   in_data              : lane i at bits [i*WIDTH +: WIDTH]
//   in_mode, in_mask     : routing for this beat, captured on acceptance
//   out_valid/out_ready  : output handshake
//   out_data             : permuted lanes (registered)
//   beat_count           : completed output handshakes, wrapping
module spider_mesh
    import spider_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter int LOG2L = $clog2(LANES),
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [1:0]             in_mode,
    input  logic [LOG2L-1:0]       in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       beat_count
);

    localparam int STAGES = LOG2L + 2;
    localparam int DW     = LANES * WIDTH;

    // Element k is the input of stage k. Element STAGES is the mesh output.
    logic [STAGES:0]             vld_c;
    logic [STAGES:0]             rdy_c;
    logic [STAGES:0][DW-1:0]     dat_c;
    logic [STAGES:0][1:0]        mode_c;
    logic [STAGES:0][LOG2L-1:0]  mask_c;

    logic [CNT_W-1:0] count_q, count_d;

    assign vld_c[0]      = in_valid;
    assign dat_c[0]      = in_data;
    assign mode_c[0]     = in_mode;
    assign mask_c[0]     = in_mask;
    assign in_ready      = rdy_c[0];
    assign rdy_c[STAGES] = out_ready;
    assign out_valid     = vld_c[STAGES];
    assign out_data      = dat_c[STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Stage 0 and the last stage are plain registers.
            // Stage k in between is butterfly stage k-1.
            localparam int BS = (gi >= 1 && gi <= LOG2L) ? gi - 1 : -1;
            spider_stage #(
                .LANES (LANES),
                .WIDTH (WIDTH),
                .LOG2L (LOG2L),
                .BFLY_S(BS)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .up_valid_i (vld_c[gi]),
                .up_ready_o (rdy_c[gi]),
                .up_data_i  (dat_c[gi]),
                .up_mode_i  (mode_c[gi]),
                .up_mask_i  (mask_c[gi]),
                .dn_valid_o (vld_c[gi+1]),
                .dn_ready_i (rdy_c[gi+1]),
                .dn_data_o  (dat_c[gi+1]),
                .dn_mode_o  (mode_c[gi+1]),
                .dn_mask_o  (mask_c[gi+1])
            );
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (out_valid && out_ready) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign beat_count = count_q;

endmodule

// File: tb/tb_spider_mesh.sv
module tb_spider_mesh;

    localparam int LANES  = 4;
    localparam int WIDTH  = 8;
    localparam int DW     = LANES * WIDTH;
    localparam int STAGES = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_mode;
    logic [1:0]    in_mask;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [15:0]   beat_count;

    spider_mesh #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .beat_count(beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          acc_cyc_q[$];
    int          obs_cyc_q[$];
    int          cyc;
    logic [15:0] exp_count;

    // Reference permutation taken directly from the lane equations.
    function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] m,
                                          input logic [1:0] mask);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < LANES; j++) begin
            int src;
            case (m)
                2'd1:    src = LANES - 1 - j;
                2'd2:    src = j ^ int'(mask);
                default: src = j;
            endcase
            r[j*WIDTH +: WIDTH] = d[src*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    // One clock. Entered at a negedge with the inputs already driven.
    // Records the handshakes that complete at the coming posedge, then
    // returns at the next negedge.
    task automatic tick(output logic acc, output logic emit);
        #2;
        acc  = rst_n && in_valid && in_ready;
        emit = rst_n && out_valid && out_ready;
        if (acc) begin
            exp_q.push_back(model(in_data, in_mode, in_mask));
            acc_cyc_q.push_back(cyc);
        end
        if (emit) begin
            obs_q.push_back(out_data);
            obs_cyc_q.push_back(cyc);
            exp_count = exp_count + 16'd1;
        end
        if (!rst_n) exp_count = '0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        logic a, e;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        tick(a, e);
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        acc_cyc_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic test_reset();
        logic a, e;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick(a, e);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready_during: got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
        tick(a, e);
        tick(a, e);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready_after: got %b expected 1", in_ready);
        end
        tests_run++;
        if (beat_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_beat_count: got %0d expected 0", beat_count);
        end
        tests_run++;
        if (out_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
        $display("[TB] reset: out_valid=%b in_ready=%b beat_count=%0d", out_valid, in_ready, beat_count);
    endtask

    task automatic test_modes();
        logic [1:0]  modes[4];
        logic [1:0]  masks[4];
        logic [31:0] wants[4];
        logic        a, e;
        logic [31:0] got;
        logic [31:0] ev;
        int          lat;
        modes = '{2'd0, 2'd1, 2'd2, 2'd2};
        masks = '{2'b00, 2'b00, 2'b01, 2'b10};
        wants = '{32'h44332211, 32'h11223344, 32'h33441122, 32'h22114433};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'b1;
            in_data   = 32'h44332211;
            in_mode   = modes[k];
            in_mask   = masks[k];
            out_ready = 1'b1;
            tick(a, e);
            in_valid = 1'b0;
            in_data  = 32'hDEADBEEF;
            for (int w = 0; w < 12 && obs_q.size() == 0; w++) tick(a, e);
            tests_run++;
            if (obs_q.size() == 0 || acc_cyc_q.size() == 0) begin
                tests_failed++;
                $display("FAIL mode%0d_timeout: got no output expected %h", k, wants[k]);
            end else begin
                got = obs_q.pop_front();
                ev  = exp_q.pop_front();
                lat = obs_cyc_q.pop_front() - acc_cyc_q.pop_front();
                if (got !== wants[k]) begin
                    tests_failed++;
                    $display("FAIL mode%0d_data: got %h expected %h", k, got, wants[k]);
                end
                tests_run++;
                if (lat != STAGES) begin
                    tests_failed++;
                    $display("FAIL mode%0d_latency: got %0d ticks expected %0d", k, lat, STAGES);
                end
                $display("[TB] mode=%0d mask=%b out=%h model=%h latency=%0d", modes[k], masks[k], got, ev, lat);
            end
            tick(a, e);
            tests_run++;
            if (beat_count !== 16'(k + 1)) begin
                tests_failed++;
                $display("FAIL mode%0d_beat_count: got %0d expected %0d", k, beat_count, k + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic a, e;
        int   sent;
        int   emitted;
        logic saw_stall;
        apply_reset();
        sent = 0;
        emitted = 0;
        saw_stall = 1'b0;
        for (int c = 0; c < 80 && (sent < 10 || emitted < 10); c++) begin
            in_valid  = (sent < 10);
            in_data   = $urandom;
            in_mode   = 2'(sent % 4);
            in_mask   = 2'($urandom_range(0, 3));
            out_ready = !(c >= 3 && c < 8);
            #1;
            if (!in_ready) begin
                saw_stall = 1'b1;
                tests_run++;
                if (sent - emitted != 4) begin
                    tests_failed++;
                    $display("FAIL stream_outstanding: got %0d expected 4", sent - emitted);
                end
            end
            if (out_valid && !out_ready && emitted < exp_q.size()) begin
                tests_run++;
                if (out_data !== exp_q[emitted]) begin
                    tests_failed++;
                    $display("FAIL stream_stall_data: got %h expected %h", out_data, exp_q[emitted]);
                end
            end
            tick(a, e);
            if (a) sent++;
            if (e) emitted++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (!saw_stall) begin
            tests_failed++;
            $display("FAIL stream_in_ready_drop: got in_ready always 1 expected a drop to 0");
        end
        tests_run++;
        if (obs_q.size() != 10) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d beats expected 10", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL stream_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
            $display("[TB] stream beat %0d out=%h expect=%h", i, obs_q[i], exp_q[i]);
        end
        tick(a, e);
        tests_run++;
        if (beat_count !== 16'd10) begin
            tests_failed++;
            $display("FAIL stream_beat_count: got %0d expected 10", beat_count);
        end
    endtask

    task automatic test_reset_inflight();
        logic a, e;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0A0A0A0 + i;
            in_mode  = 2'd1;
            in_mask  = 2'd0;
            tick(a, e);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick(a, e);
        rst_n = 1'b1;
        exp_q.delete();
        acc_cyc_q.delete();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL inflight_out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (beat_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL inflight_beat_count: got %0d expected 0", beat_count);
        end
        for (int i = 0; i < 8; i++) tick(a, e);
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL inflight_stale: got %0d beats expected 0", obs_q.size());
        end
        $display("[TB] reset in flight: stale beats=%0d beat_count=%0d", obs_q.size(), beat_count);
    endtask

    task automatic test_wrap();
        logic a, e;
        int   sent;
        int   emitted;
        apply_reset();
        sent = 0;
        emitted = 0;
        in_mode = 2'd0;
        in_mask = 2'd0;
        out_ready = 1'b1;
        for (int c = 0; c < 66000 && emitted < 65535; c++) begin
            in_valid = (sent < 65535);
            in_data  = 32'(c);
            tick(a, e);
            if (a) sent++;
            if (e) emitted++;
            exp_q.delete();
            obs_q.delete();
            acc_cyc_q.delete();
            obs_cyc_q.delete();
        end
        in_valid = 1'b0;
        tick(a, e);
        tests_run++;
        if (beat_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL wrap_preload: got %h expected ffff", beat_count);
        end
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        tick(a, e);
        in_valid = 1'b0;
        for (int w = 0; w < 12 && obs_q.size() == 0; w++) tick(a, e);
        tick(a, e);
        tests_run++;
        if (beat_count !== 16'h0000 || obs_q.size() != 1) begin
            tests_failed++;
            $display("FAIL wrap_to_zero: got %h (beats %0d) expected 0000 (beats 1)", beat_count, obs_q.size());
        end
        $display("[TB] wrap: beat_count=%h", beat_count);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        exp_count    = '0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_mode      = '0;
        in_mask      = '0;
        out_ready    = 1'b0;
        @(negedge clk);
        test_reset();
        test_modes();
        test_back_to_back();
        test_reset_inflight();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spider_mesh.md
# spider_mesh

Parametrised, pipelined successor to the fixed four-leg spider test netlist. LANES data channels enter, pass through an input register stage, log2(LANES) registered butterfly stages of 2x2 swap cells and an output register stage, then exit. Lane routing is selectable per beat, and the whole lane vector moves in lock-step under one valid/ready handshake. It serves as a scalable, sequential schematic-viewer test block and as a reusable lane-permutation pipeline.

## Interface
- LANES, default 4: lane count; must be a power of 2 and at least 2.
- WIDTH, default 8: bits per lane.
- LOG2L, default $clog2(LANES): derived; do not override.
- CNT_W, default 16: width of the beat counter.
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block accepts the beat this cycle.
- in_data, input, LANES*WIDTH: lane i occupies bits [i*WIDTH +: WIDTH].
- in_mode, input, 2: routing mode; captured with the beat.
- in_mask, input, LOG2L: swap mask, used in MASK mode only.
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: downstream accepts.
- out_data, output, LANES*WIDTH: permuted lanes.
- beat_count, output, CNT_W: number of completed output handshakes.

## Operation
- Modes, decoded from in_mode:
  - 0, STRAIGHT: no swaps. out lane j = in lane j.
  - 1, REVERSE: all cells swap. out lane j = in lane (LANES-1-j).
  - 2, MASK: stage s swaps all of its cells when in_mask[s] = 1. out lane j = in lane (j XOR in_mask).
  - 3, reserved: behaves as STRAIGHT.
- Butterfly stage s (0..LOG2L-1) pairs lanes i and i+2^s for each i with bit s = 0.
- Mode and mask are stored in each stage alongside the data. A beat's routing is fixed at acceptance. Changing in_mode while beats are in flight affects only later beats.
- Pipeline has STAGES = LOG2L+2 register stages. Each stage holds a full bit.
- Stage k loads when it is empty, or when stage k+1 accepts its beat (or, for the last stage, when out_ready = 1).
- in_ready = stage 0 is empty or stage 0 advances this cycle. The ready chain is combinational and there are no bubbles, so sustained throughput is 1 beat per clock.
- beat_count increments on every out_valid && out_ready. It wraps from 2^CNT_W-1 to 0.
- Reset (rst_n = 0 at a clock edge):
  - clears all full bits, data, mode and mask registers, and beat_count;
  - in-flight beats are discarded with no output;
  - takes priority over any simultaneous handshake.

## Timing
- Reset values: out_valid = 0, out_data = 0, beat_count = 0. in_ready = 1 during and after reset, because the pipeline is empty.
- Latency: a beat accepted at edge N is presented on out_valid/out_data after edge N+STAGES-1 (3 cycles for LANES = 4), provided there is no backpressure.
- out_data, out_valid and beat_count are registered. in_ready is combinational from out_ready and the full bits.
- Backpressure: with out_ready = 0, the pipeline fills after STAGES accepted beats, then in_ready = 0. out_data stays stable while out_valid = 1 and out_ready = 0.
- Simultaneous accept and emit when full: both handshakes complete in the same cycle and no beat is lost or duplicated.
- in_data is ignored when in_valid = 0.

## Structure
- Package spider_pkg holds:
  - enum mode_e: STRAIGHT = 0, REVERSE = 1, MASK = 2;
  - function swap_en(mode, mask, stage) returning that stage's swap decision.
- One sub-module, spider_stage: a single register stage with a full bit, valid/ready and data/mode/mask registers. Parameter BFLY_S selects the swap distance, with -1 meaning no swap.
- spider_mesh instantiates STAGES copies of spider_stage via a generate loop and drives beat_count.

## Test plan
All scenarios use LANES = 4 and WIDTH = 8.
- Reset then idle: out_valid = 0, in_ready = 1, beat_count = 0.
- STRAIGHT: in_data = {8'h44, 8'h33, 8'h22, 8'h11} with out_ready = 1 -> out_data identical exactly 3 cycles later; beat_count = 1.
- REVERSE on the same data -> {8'h11, 8'h22, 8'h33, 8'h44}.
- MASK with in_mask = 2'b01 -> {8'h33, 8'h44, 8'h11, 8'h22}. MASK with in_mask = 2'b10 -> {8'h22, 8'h11, 8'h44, 8'h33}.
- Stream 10 beats with changing modes while out_ready is held low for 5 cycles mid-stream:
  - in_ready drops after 4 outstanding beats;
  - all 10 beats emerge in order, each with its own mode applied;
  - beat_count = 10.
- Assert rst_n low for one cycle with 3 beats in flight -> next cycle out_valid = 0 and beat_count = 0, with no stale beat ever emitted. Separately, preload beat_count to 16'hFFFF by 65535 beats, then one more beat -> beat_count = 0.
